clock_display_scan: RTL

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

---
 rtl/clock_disp_pkg.sv | 58 +++++
 rtl/clock_bin2bcd.sv | 58 +++++
 rtl/clock_display_scan.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the six-digit clock display scanner.
// Seven-segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CONV_S,
    S_CONV_M,
    S_CONV_H,
    S_COMMIT
  } disp_state_e;

  localparam int NUM_DIGITS = 6;
  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HR_MAX     = 23;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit codes above 9 carry the two special glyphs.
  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_DASH  = 4'hF;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] code
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (code)
      4'd0:       s = SEG_0;
      4'd1:       s = SEG_1;
      4'd2:       s = SEG_2;
      4'd3:       s = SEG_3;
      4'd4:       s = SEG_4;
      4'd5:       s = SEG_5;
      4'd6:       s = SEG_6;
      4'd7:       s = SEG_7;
      4'd8:       s = SEG_8;
      4'd9:       s = SEG_9;
      CODE_DASH:  s = SEG_DASH;
      default:    s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_bin2bcd.sv
// Sequential binary-to-tens/ones converter, one subtraction of ten per cycle.
// The first subtraction is folded into the start cycle.
module clock_bin2bcd
  import clock_disp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [5:0] val_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [5:0] rem_q, rem_d;
  logic [3:0] tens_q, tens_d;
  logic       busy_q, busy_d;

  always_comb begin
    rem_d  = rem_q;
    tens_d = tens_q;
    busy_d = busy_q;
    if (start_i) begin
      busy_d = 1'b1;
      if (val_i >= 6'd10) begin
        rem_d  = val_i - 6'd10;
        tens_d = 4'd1;
      end else begin
        rem_d  = val_i;
        tens_d = 4'd0;
      end
    end else if (busy_q) begin
      if (rem_q >= 6'd10) begin
        rem_d  = rem_q - 6'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      tens_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      tens_q <= tens_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (rem_q < 6'd10);
  assign tens_o = tens_q;
  assign ones_o = rem_q[3:0];

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH:MM:SS display with per-frame BCD conversion.
// Define CLOCK_DISP_BLANK_LEAD_EN to blank a leading zero in hours-tens.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_tick
);

`ifdef CLOCK_DISP_BLANK_LEAD_EN
  localparam logic LEAD_BLANK = 1'b1;
`else
  localparam logic LEAD_BLANK = 1'b0;
`endif

  localparam logic [15:0] PRE_TC = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NUM_DIGITS - 1);

  disp_state_e state_q, state_d;

  logic [15:0] pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic        tick_q, tick_d;
  logic        boot_q, boot_d;
  logic        live_q, live_d;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic [5:0]  min_q;
  logic [4:0]  hr_q;
  logic        s_bad_q, m_bad_q, h_bad_q;
  logic [3:0]  s_t_q, s_o_q, m_t_q, m_o_q, h_t_q, h_o_q;
  logic [3:0]  dig_q [NUM_DIGITS];
  logic [3:0]  dig_d [NUM_DIGITS];

  logic        cv_start, cv_done;
  logic [5:0]  cv_val;
  logic [3:0]  cv_tens, cv_ones;

  clock_bin2bcd u_bin2bcd (
    .clk_i   (Clk),
    .rst_ni  (reset_n),
    .start_i (cv_start),
    .val_i   (cv_val),
    .done_o  (cv_done),
    .tens_o  (cv_tens),
    .ones_o  (cv_ones)
  );

  // Scan timing: prescaler, digit index and frame pulse.
  always_comb begin
    pre_d  = pre_q + 16'd1;
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (pre_q == PRE_TC) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    boot_d   = boot_q;
    live_d   = live_q;
    cv_start = 1'b0;
    cv_val   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (boot_q || tick_q) begin
          state_d = S_LATCH;
          boot_d  = 1'b0;
        end
      end
      S_LATCH: begin
        cv_start = 1'b1;
        cv_val   = seconds;
        state_d  = S_CONV_S;
      end
      S_CONV_S: begin
        if (cv_done) begin
          cv_start = 1'b1;
          cv_val   = min_q;
          state_d  = S_CONV_M;
        end
      end
      S_CONV_M: begin
        if (cv_done) begin
          cv_start = 1'b1;
          cv_val   = {1'b0, hr_q};
          state_d  = S_CONV_H;
        end
      end
      S_CONV_H: begin
        if (cv_done) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        live_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dig_d[0] = s_bad_q ? CODE_DASH : s_o_q;
    dig_d[1] = s_bad_q ? CODE_DASH : s_t_q;
    dig_d[2] = m_bad_q ? CODE_DASH : m_o_q;
    dig_d[3] = m_bad_q ? CODE_DASH : m_t_q;
    dig_d[4] = h_bad_q ? CODE_DASH : h_o_q;
    if (h_bad_q)
      dig_d[5] = CODE_DASH;
    else if (LEAD_BLANK && (h_t_q == 4'd0))
      dig_d[5] = CODE_BLANK;
    else
      dig_d[5] = h_t_q;
  end

  always_comb begin
    an_d  = 6'h3F;
    seg_d = SEG_BLANK;
    if (live_q) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = seg_encode(dig_q[idx_q]);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      boot_q  <= 1'b1;
      live_q  <= 1'b0;
      an_q    <= 6'h3F;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      boot_q  <= boot_d;
      live_q  <= live_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // Conversion datapath; committed digits only change in COMMIT.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q   <= '0;
      hr_q    <= '0;
      s_bad_q <= 1'b0;
      m_bad_q <= 1'b0;
      h_bad_q <= 1'b0;
      s_t_q   <= '0;
      s_o_q   <= '0;
      m_t_q   <= '0;
      m_o_q   <= '0;
      h_t_q   <= '0;
      h_o_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= '0;
    end else begin
      if (state_q == S_LATCH) begin
        min_q   <= minutes;
        hr_q    <= hours;
        s_bad_q <= seconds > 6'(SEC_MAX);
        m_bad_q <= minutes > 6'(MIN_MAX);
        h_bad_q <= hours > 5'(HR_MAX);
      end
      if (state_q == S_CONV_S && cv_done) begin
        s_t_q <= cv_tens;
        s_o_q <= cv_ones;
      end
      if (state_q == S_CONV_M && cv_done) begin
        m_t_q <= cv_tens;
        m_o_q <= cv_ones;
      end
      if (state_q == S_CONV_H && cv_done) begin
        h_t_q <= cv_tens;
        h_o_q <= cv_ones;
      end
      if (state_q == S_COMMIT) begin
        for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= dig_d[i];
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule
